// File: rtl/aidc_lite_pkg.sv
// Shared constants and types for the AIDC-Lite block collector.
package aidc_lite_pkg;

    localparam int AIDC_WORD_W      = 64;
    localparam int AIDC_BLK_WORDS   = 8;
    localparam int AIDC_LIMIT_WORDS = 7;
    localparam int AIDC_IDX_W       = $clog2(AIDC_BLK_WORDS);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILL,
        BANK_FULL,
        BANK_DRAIN
    } bank_state_t;

    typedef struct packed {
        logic [3:0] len;
        logic       fail;
    } bank_meta_t;

endpackage

// File: rtl/aidc_lite_block_collector_if.sv
// Packed-word input stream and valid/ready block output stream of the collector.
interface aidc_lite_block_collector_if;

    logic                                 valid_i;
    logic [aidc_lite_pkg::AIDC_WORD_W-1:0] data_i;
    logic                                 last_i;

    logic                                 out_valid_o;
    logic                                 out_ready_i;
    logic [aidc_lite_pkg::AIDC_WORD_W-1:0] out_data_o;
    logic [aidc_lite_pkg::AIDC_IDX_W-1:0]  out_idx_o;
    logic                                 out_last_o;
    logic                                 out_fail_o;

    modport slave (
        input  valid_i, data_i, last_i, out_ready_i,
        output out_valid_o, out_data_o, out_idx_o, out_last_o, out_fail_o
    );

    modport master (
        output valid_i, data_i, last_i, out_ready_i,
        input  out_valid_o, out_data_o, out_idx_o, out_last_o, out_fail_o
    );

endinterface

// File: rtl/aidc_lite_word_bank.sv
// One collector bank: 8x64 word storage (one write, one async read) plus block metadata.
module aidc_lite_word_bank
    import aidc_lite_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AIDC_IDX_W-1:0]  wr_addr,
    input  logic [AIDC_WORD_W-1:0] wr_data,
    input  logic                   meta_we,
    input  bank_meta_t             meta_d,
    input  logic [AIDC_IDX_W-1:0]  rd_addr,
    output logic [AIDC_WORD_W-1:0] rd_data,
    output bank_meta_t             meta_q
);

    logic [AIDC_WORD_W-1:0] mem [AIDC_BLK_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
        end else if (meta_we) begin
            meta_q <= meta_d;
        end
    end

endmodule

// File: rtl/aidc_lite_block_collector.sv
// Ping-pong block collector: fills two word banks alternately, drains over valid/ready.
// Optional AIDC_LITE_COLLECT_STATS_EN adds saturating block/drop statistics outputs.
//
// state      | meaning
// BANK_FREE  | empty, may take the next block
// BANK_FILL  | block mid-fill, words being written
// BANK_FULL  | block closed, waiting for the drain pointer
// BANK_DRAIN | beats being presented on the output
module aidc_lite_block_collector
    import aidc_lite_pkg::*;
#(
    parameter int WORD_W      = AIDC_WORD_W,
    parameter int BLK_WORDS   = AIDC_BLK_WORDS,
    parameter int LIMIT_WORDS = AIDC_LIMIT_WORDS
) (
    input  logic                            clk,
    input  logic                            rst,
    aidc_lite_block_collector_if.slave      bus,
    output logic                            ovf_o,
    output logic                            busy_o
`ifdef AIDC_LITE_COLLECT_STATS_EN
    ,
    output logic [31:0]                     stat_comp_o,
    output logic [31:0]                     stat_fail_o,
    output logic [15:0]                     stat_ovf_o
`endif
);

    localparam int                IDX_W     = $clog2(BLK_WORDS);
    localparam int                CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLK_WORDS);
    localparam logic [3:0]        LIMIT_LEN = 4'(LIMIT_WORDS);

    bank_state_t        bank_state     [2];
    bank_state_t        bank_state_nxt [2];
    bank_meta_t         meta_q         [2];
    logic [WORD_W-1:0]  rd_data        [2];

    logic               fill_bank;
    logic               drain_bank;
    logic               dropping;
    logic [CNT_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    logic               handshake;
    logic               final_hs;
    logic               fill_busy;
    logic               first_beat;
    logic               accept_first;
    logic               drop_first;
    logic               beat_acc;
    logic               overrun;
    logic               close_blk;
    logic [3:0]         close_len;
    bank_meta_t         close_meta;

    logic               out_valid;
    bank_state_t        dr_state;
    bank_meta_t         dr_meta;

    assign handshake  = out_valid & bus.out_ready_i;
    assign final_hs   = handshake & bus.out_last_o;

    // A bank whose final beat leaves this cycle counts as free for a new block.
    assign fill_busy    = (bank_state[fill_bank] == BANK_FILL);
    assign first_beat   = bus.valid_i & ~dropping & ~fill_busy;
    assign accept_first = first_beat & ((bank_state[fill_bank] == BANK_FREE) |
                                        (final_hs & (drain_bank == fill_bank)));
    assign drop_first   = first_beat & ~accept_first;
    assign beat_acc     = bus.valid_i & ~dropping & (fill_busy | accept_first);
    assign close_blk    = beat_acc & bus.last_i;

    // wr_idx parks at BLK_WORDS once the bank is full; further beats only mark the overrun.
    assign overrun    = (wr_idx == CNT_FULL);
    assign close_len  = overrun ? 4'(BLK_WORDS) : 4'(wr_idx) + 4'd1;

    always_comb begin
        close_meta      = '0;
        close_meta.len  = close_len;
        close_meta.fail = overrun | (close_len > LIMIT_LEN);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        aidc_lite_word_bank u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (beat_acc & ~overrun & (fill_bank == 1'(b))),
            .wr_addr (wr_idx[IDX_W-1:0]),
            .wr_data (bus.data_i),
            .meta_we (close_blk & (fill_bank == 1'(b))),
            .meta_d  (close_meta),
            .rd_addr (rd_idx),
            .rd_data (rd_data[b]),
            .meta_q  (meta_q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank  <= 1'b0;
            drain_bank <= 1'b0;
            dropping   <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            ovf_o      <= 1'b0;
        end else begin
            if (drop_first) begin
                ovf_o <= 1'b1;
            end
            if (bus.valid_i & bus.last_i) begin
                dropping <= 1'b0;
            end else if (drop_first) begin
                dropping <= 1'b1;
            end

            if (close_blk) begin
                wr_idx    <= '0;
                fill_bank <= ~fill_bank;
            end else if (beat_acc & ~overrun) begin
                wr_idx <= wr_idx + CNT_W'(1);
            end

            if (final_hs) begin
                rd_idx     <= '0;
                drain_bank <= ~drain_bank;
            end else if (handshake) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= BANK_FREE;
            bank_state[1] <= BANK_FREE;
        end else begin
            bank_state[0] <= bank_state_nxt[0];
            bank_state[1] <= bank_state_nxt[1];
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_nxt[b] = bank_state[b];
            if ((bank_state[b] == BANK_FULL) && (drain_bank == 1'(b))) begin
                bank_state_nxt[b] = BANK_DRAIN;
            end
            if (final_hs && (drain_bank == 1'(b))) begin
                bank_state_nxt[b] = BANK_FREE;
            end
            if (beat_acc && (fill_bank == 1'(b))) begin
                bank_state_nxt[b] = bus.last_i ? BANK_FULL : BANK_FILL;
            end
        end
    end

    // Outputs decode registered state only, so they hold while the sink stalls.
    always_comb begin
        dr_state        = bank_state[drain_bank];
        dr_meta         = meta_q[drain_bank];
        out_valid       = (dr_state == BANK_FULL) | (dr_state == BANK_DRAIN);
        bus.out_valid_o = out_valid;
        bus.out_fail_o  = out_valid & dr_meta.fail;
        bus.out_last_o  = out_valid & (dr_meta.fail | (4'(rd_idx) == dr_meta.len - 4'd1));
        bus.out_data_o  = (out_valid & ~dr_meta.fail) ? rd_data[drain_bank] : '0;
        bus.out_idx_o   = rd_idx;
        busy_o          = (bank_state[0] != BANK_FREE) | (bank_state[1] != BANK_FREE);
    end

`ifdef AIDC_LITE_COLLECT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_comp_o <= '0;
            stat_fail_o <= '0;
            stat_ovf_o  <= '0;
        end else begin
            if (final_hs && !bus.out_fail_o && !(&stat_comp_o)) begin
                stat_comp_o <= stat_comp_o + 32'd1;
            end
            if (final_hs && bus.out_fail_o && !(&stat_fail_o)) begin
                stat_fail_o <= stat_fail_o + 32'd1;
            end
            if (drop_first && !(&stat_ovf_o)) begin
                stat_ovf_o <= stat_ovf_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aidc_lite_block_collector.sv
// Directed bench for the block collector: per-cycle vector table plus hand-written corner sequences.
module tb_aidc_lite_block_collector;

    logic clk;
    logic rst;
    logic ovf;
    logic busy;
`ifdef AIDC_LITE_COLLECT_STATS_EN
    logic [31:0] stat_comp;
    logic [31:0] stat_fail;
    logic [15:0] stat_ovf;
`endif

    aidc_lite_block_collector_if bus ();

    aidc_lite_block_collector dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .ovf_o  (ovf),
        .busy_o (busy)
`ifdef AIDC_LITE_COLLECT_STATS_EN
        ,
        .stat_comp_o (stat_comp),
        .stat_fail_o (stat_fail),
        .stat_ovf_o  (stat_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        l;
        logic [63:0] d;
        logic        r;
        logic        ev;
        logic [2:0]  ei;
        logic [63:0] ed;
        logic        el;
        logic        ef;
        logic        eb;
    } vec_t;

    vec_t vq [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [63:0] dw(input int blk, input int k);
        return {8'(blk), 24'hC0FFEE, 32'(k + 1)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic l, input logic [63:0] d, input logic r,
                       input logic ev, input int ei, input logic [63:0] ed,
                       input logic el, input logic ef, input logic eb);
        vec_t t;
        t.v = v; t.l = l; t.d = d; t.r = r;
        t.ev = ev; t.ei = 3'(ei); t.ed = ed; t.el = el; t.ef = ef; t.eb = eb;
        vq.push_back(t);
    endtask

    task automatic send_blk(input int blk, input int n);
        for (int k = 0; k < n; k++) add(1'b1, k == n - 1, dw(blk, k), 1'b1, 1'b0, 0, '0, 1'b0, 1'b0, k != 0);
    endtask

    task automatic exp_beat(input logic r, input int idx, input logic [63:0] d, input logic l, input logic f);
        add(1'b0, 1'b0, '0, r, 1'b1, idx, d, l, f, 1'b1);
    endtask

    task automatic idle_row();
        add(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive(input logic v, input logic l, input logic [63:0] d);
        bus.valid_i = v;
        bus.last_i  = l;
        bus.data_i  = d;
    endtask

    task automatic beat_chk(input string name, input int idx, input logic [63:0] d, input logic l);
        chk({name, " valid"}, 64'(bus.out_valid_o), 64'(1));
        chk({name, " idx"},   64'(bus.out_idx_o), 64'(idx));
        chk({name, " data"},  bus.out_data_o, d);
        chk({name, " last"},  64'(bus.out_last_o), 64'(l));
    endtask

    initial begin
        int got;

        rst = 1'b1;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 1'b0, '0);
        step();
        step();
        chk("reset valid", 64'(bus.out_valid_o), 64'(0));
        chk("reset last",  64'(bus.out_last_o), 64'(0));
        chk("reset fail",  64'(bus.out_fail_o), 64'(0));
        chk("reset idx",   64'(bus.out_idx_o), 64'(0));
        chk("reset data",  bus.out_data_o, 64'(0));
        chk("reset ovf",   64'(ovf), 64'(0));
        chk("reset busy",  64'(busy), 64'(0));
        rst = 1'b0;

        // 5-word block drained without stalls
        send_blk(1, 5);
        for (int k = 0; k < 5; k++) exp_beat(1'b1, k, dw(1, k), k == 4, 1'b0);
        idle_row();
        // 8 words exceeds the limit of 7: one fail beat
        send_blk(2, 8);
        exp_beat(1'b1, 0, '0, 1'b1, 1'b1);
        idle_row();
        // 10 words: overrun words discarded, one fail beat
        send_blk(3, 10);
        exp_beat(1'b1, 0, '0, 1'b1, 1'b1);
        idle_row();
        // 7 words sits exactly at the limit and passes
        send_blk(4, 7);
        for (int k = 0; k < 7; k++) exp_beat(1'b1, k, dw(4, k), k == 6, 1'b0);
        idle_row();
        // ready toggling: each beat held for one stalled cycle, then transferred
        send_blk(5, 4);
        for (int k = 0; k < 4; k++) begin
            exp_beat(1'b0, k, dw(5, k), k == 3, 1'b0);
            exp_beat(1'b1, k, dw(5, k), k == 3, 1'b0);
        end
        idle_row();
        // single-beat block
        send_blk(6, 1);
        exp_beat(1'b1, 0, dw(6, 0), 1'b1, 1'b0);
        idle_row();

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].l, vq[i].d);
            bus.out_ready_i = vq[i].r;
            chk($sformatf("vec%0d valid", i), 64'(bus.out_valid_o), 64'(vq[i].ev));
            if (vq[i].ev) begin
                chk($sformatf("vec%0d idx", i),  64'(bus.out_idx_o), 64'(vq[i].ei));
                chk($sformatf("vec%0d data", i), bus.out_data_o, vq[i].ed);
                chk($sformatf("vec%0d last", i), 64'(bus.out_last_o), 64'(vq[i].el));
                chk($sformatf("vec%0d fail", i), 64'(bus.out_fail_o), 64'(vq[i].ef));
            end
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vq[i].eb));
            step();
        end
        chk("table ovf", 64'(ovf), 64'(0));

        // Both banks stalled, third block dropped
        bus.out_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 3; k++) begin
                if (b == 2 && k == 0) chk("seqA ovf before drop", 64'(ovf), 64'(0));
                drive(1'b1, k == 2, dw(10 + b, k));
                step();
            end
        end
        drive(1'b0, 1'b0, '0);
        chk("seqA ovf set", 64'(ovf), 64'(1));
        chk("seqA busy", 64'(busy), 64'(1));
        beat_chk("seqA stalled head", 0, dw(10, 0), 1'b0);
        step();
        beat_chk("seqA still held", 0, dw(10, 0), 1'b0);
        bus.out_ready_i = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            if (bus.out_valid_o) begin
                beat_chk($sformatf("seqA beat%0d", got), got % 3, dw(10 + got / 3, got % 3), got % 3 == 2);
                got++;
            end
            step();
        end
        chk("seqA beat count", 64'(got), 64'(6));
        chk("seqA no extra beat", 64'(bus.out_valid_o), 64'(0));
        chk("seqA ovf sticky", 64'(ovf), 64'(1));

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst clears ovf", 64'(ovf), 64'(0));

        // Final beat of bank 0 and first word of the next block in the same cycle
        bus.out_ready_i = 1'b0;
        drive(1'b1, 1'b0, dw(20, 0)); step();
        drive(1'b1, 1'b1, dw(20, 1)); step();
        drive(1'b1, 1'b0, dw(21, 0)); step();
        drive(1'b1, 1'b1, dw(21, 1)); step();
        drive(1'b0, 1'b0, '0);
        bus.out_ready_i = 1'b1;
        beat_chk("seqB P0", 0, dw(20, 0), 1'b0); step();
        beat_chk("seqB P1", 1, dw(20, 1), 1'b1);
        drive(1'b1, 1'b0, dw(22, 0)); step();
        beat_chk("seqB Q0", 0, dw(21, 0), 1'b0);
        drive(1'b1, 1'b1, dw(22, 1)); step();
        drive(1'b0, 1'b0, '0);
        beat_chk("seqB Q1", 1, dw(21, 1), 1'b1); step();
        beat_chk("seqB R0", 0, dw(22, 0), 1'b0); step();
        beat_chk("seqB R1", 1, dw(22, 1), 1'b1); step();
        chk("seqB done valid", 64'(bus.out_valid_o), 64'(0));
        chk("seqB ovf", 64'(ovf), 64'(0));
        chk("seqB busy", 64'(busy), 64'(0));

        // Reset with one bank full and the other mid-fill
        bus.out_ready_i = 1'b0;
        drive(1'b1, 1'b0, dw(30, 0)); step();
        drive(1'b1, 1'b1, dw(30, 1)); step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, dw(31, k));
            step();
        end
        drive(1'b0, 1'b0, '0);
        chk("seqC pre-rst valid", 64'(bus.out_valid_o), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("seqC post-rst valid", 64'(bus.out_valid_o), 64'(0));
        chk("seqC post-rst busy", 64'(busy), 64'(0));
        bus.out_ready_i = 1'b1;
        drive(1'b1, 1'b0, dw(32, 0)); step();
        drive(1'b1, 1'b1, dw(32, 1));
        chk("seqC fill valid", 64'(bus.out_valid_o), 64'(0));
        step();
        drive(1'b0, 1'b0, '0);
        beat_chk("seqC T0", 0, dw(32, 0), 1'b0); step();
        beat_chk("seqC T1", 1, dw(32, 1), 1'b1); step();
        chk("seqC done valid", 64'(bus.out_valid_o), 64'(0));
        chk("seqC done busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
